// File: rtl/radix2_divider_pkg.sv
// Shared types for the RV32M divide unit: the funct3[1:0] operation encoding.
package radix2_divider_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

endpackage

// File: rtl/radix2_divider.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU, start/done handshake,
// flushable while in flight.
//
// state        | meaning
// IDLE         | waiting for start; operands captured on accept
// ITERATE      | one restoring step per cycle, 32 cycles
// FIXUP        | apply quotient/remainder sign, register result
// DONE         | done pulse, result valid
// DONE_SPECIAL | done pulse for divide-by-zero / signed overflow
module radix2_divider
    import radix2_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       div_op,
    input  logic             start,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ITERATE,
        FIXUP,
        DONE,
        DONE_SPECIAL
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    state_t           state;
    div_op_t          op_r;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [CNT_W-1:0] cnt;

    div_op_t          op_in;
    logic             signed_in;
    logic             rem_in;
    logic             by_zero;
    logic             overflow;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH:0]   trial;
    logic             rem_op;
    logic [WIDTH-1:0] fix_x;
    logic [WIDTH-1:0] result_next;

    always_comb begin
        op_in     = div_op_t'(div_op);
        signed_in = (op_in == DIV) || (op_in == REM);
        rem_in    = (op_in == REM) || (op_in == REMU);
        by_zero   = (b == '0);
        overflow  = signed_in && (a == MIN_NEG) && (b == '1);
        // |MIN_NEG| wraps to itself, which is the correct magnitude read unsigned.
        abs_a     = (signed_in && a[WIDTH-1]) ? negate(a) : a;
        abs_b     = (signed_in && b[WIDTH-1]) ? negate(b) : b;

        special_res = '0;
        if (by_zero)
            special_res = rem_in ? a : '1;
        else
            special_res = rem_in ? '0 : MIN_NEG;

        rem_s = {rem[WIDTH-1:0], quot[WIDTH-1]};
        trial = rem_s - {1'b0, divisor};

        rem_op      = (op_r == REM) || (op_r == REMU);
        fix_x       = rem_op ? rem[WIDTH-1:0] : quot;
        result_next = (rem_op ? neg_r : neg_q) ? negate(fix_x) : fix_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_r    <= DIV;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            divisor <= '0;
            rem     <= '0;
            quot    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r <= op_in;
                        busy <= 1'b1;
                        if (by_zero || overflow) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= DONE_SPECIAL;
                        end else begin
                            neg_q   <= signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r   <= signed_in && a[WIDTH-1];
                            divisor <= abs_b;
                            rem     <= '0;
                            quot    <= abs_a;
                            cnt     <= '0;
                            state   <= ITERATE;
                        end
                    end
                end
                ITERATE: begin
                    if (!trial[WIDTH]) begin
                        rem  <= trial;
                        quot <= {quot[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= rem_s;
                        quot <= {quot[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= FIXUP;
                end
                FIXUP: begin
                    result <= result_next;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE, DONE_SPECIAL: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
